vedic_4x4_iter: RTL



---
 rtl/vedic_4x4_iter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vedic_4x4_iter.sv
// Iterative Vedic multiplier: a single half-adder 2x2 partial-product unit is
// stepped over every 2-bit digit pair, and each result is shifted into a 2*WIDTH accumulator.
module vedic_4x4_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mul_a,
    input  logic [WIDTH-1:0]   mul_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               busy
);

    localparam int HALF  = WIDTH / 2;
    localparam int STEPS = HALF * HALF;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(STEPS - 1);

    generate
        if ((WIDTH != 4) && (WIDTH != 8)) begin : g_bad_width
            $error("vedic_4x4_iter: WIDTH must be 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_in_ready;

    logic               w_accept;
    logic               w_last;
    logic [CW-1:0]      w_i;
    logic [CW-1:0]      w_j;
    logic [CW:0]        w_sh;
    logic [1:0]         w_a_dig;
    logic [1:0]         w_b_dig;
    logic               w_p00;
    logic               w_p01;
    logic               w_p10;
    logic               w_p11;
    logic               w_s1;
    logic               w_c1;
    logic               w_s2;
    logic               w_c2;
    logic [3:0]         w_pp;
    logic [2*WIDTH-1:0] w_pp_sh;

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_cnt == LAST_C);

    // Digit indices: cnt walks b-digits fastest within each a-digit.
    assign w_i     = r_cnt / HALF_C;
    assign w_j     = r_cnt % HALF_C;
    assign w_sh    = {w_i + w_j, 1'b0};
    assign w_a_dig = 2'(r_a >> {w_i, 1'b0});
    assign w_b_dig = 2'(r_b >> {w_j, 1'b0});

    // 2x2 Vedic unit: vertical and crosswise products combined by two half adders.
    assign w_p00   = w_a_dig[0] & w_b_dig[0];
    assign w_p10   = w_a_dig[1] & w_b_dig[0];
    assign w_p01   = w_a_dig[0] & w_b_dig[1];
    assign w_p11   = w_a_dig[1] & w_b_dig[1];
    assign w_s1    = w_p10 ^ w_p01;
    assign w_c1    = w_p10 & w_p01;
    assign w_s2    = w_p11 ^ w_c1;
    assign w_c2    = w_p11 & w_c1;
    assign w_pp    = {w_c2, w_s2, w_s1, w_p00};
    assign w_pp_sh = {{(2*WIDTH-4){1'b0}}, w_pp} << w_sh;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            // in_ready is registered so it is low throughout reset yet tracks IDLE afterwards.
            r_in_ready <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= mul_a;
                        r_b   <= mul_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign o_product = r_acc;

endmodule
